// File: rtl/mul_behav_pkg.sv
// Shared types and the 33x33 signed-extension multiply used by mul_behav.
package mul_behav_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Extend each operand to 33 bits per its sign flag; keep the low 64 bits of the product.
  function automatic logic [PROD_W-1:0] mul_ext(input logic [OP_W-1:0] m,
                                                input logic [OP_W-1:0] r,
                                                input logic            sign_m,
                                                input logic            sign_r);
    logic signed [OP_W:0]     a;
    logic signed [OP_W:0]     b;
    logic signed [PROD_W-1:0] p;
    a = $signed({sign_m & m[OP_W-1], m});
    b = $signed({sign_r & r[OP_W-1], r});
    p = PROD_W'(a) * PROD_W'(b);
    return p;
  endfunction

endpackage

// File: rtl/mul_behav.sv
// Fixed-latency 32x32->64 multiplier for RV32M mul/mulh/mulhsu/mulhu.
module mul_behav
  import mul_behav_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic                sign0,
  input  logic                sign1,
  input  logic [OP_W-1:0]     m,
  input  logic [OP_W-1:0]     r,
  output logic                done,
  output logic [PROD_W-1:0]   result
);

  localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OP_W-1:0]    m_q, r_q;
  logic               sign0_q, sign1_q;
  logic               load_op_c;
  logic               complete_c;
  logic [PROD_W-1:0]  prod_c;

  // State and counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: cnt holds the busy cycles still to run, completion fires when it reaches 1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (go && (LATENCY > 1)) begin
          state_n = ST_BUSY;
          cnt_n   = CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (!go || (cnt == CNT_W'(1))) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output decode: operand capture and completion strobe
  always_comb begin
    load_op_c  = 1'b0;
    complete_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load_op_c  = go;
        complete_c = go && (LATENCY == 1);
      end
      ST_BUSY: complete_c = go && (cnt == CNT_W'(1));
      default: ;
    endcase
  end

  // Single-cycle latency completes in IDLE, so it multiplies the live operands
  assign prod_c = (state == ST_IDLE) ? mul_ext(m, r, sign1, sign0)
                                     : mul_ext(m_q, r_q, sign1_q, sign0_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q     <= '0;
      r_q     <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= complete_c;
      if (load_op_c) begin
        m_q     <= m;
        r_q     <= r;
        sign0_q <= sign0;
        sign1_q <= sign1;
      end
      if (complete_c) result <= prod_c;
    end
  end

endmodule

// File: tb/tb_mul_behav.sv
// Directed bench for mul_behav with LATENCY=4.
module tb_mul_behav;

  logic        clk_core = 1'b0;
  logic        reset_n  = 1'b0;
  logic        go       = 1'b0;
  logic        sign0    = 1'b0;
  logic        sign1    = 1'b0;
  logic [31:0] m        = '0;
  logic [31:0] r        = '0;
  logic        done;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mul_behav #(.LATENCY(4)) dut (
    .clk     (clk_core),
    .reset_n (reset_n),
    .go      (go),
    .sign0   (sign0),
    .sign1   (sign1),
    .m       (m),
    .r       (r),
    .done    (done),
    .result  (result)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // Start in cycle 0, expect done only in cycle 4, then drop go
  task automatic run_op(input string tag, input logic [31:0] mv, input logic [31:0] rv,
                        input logic s0, input logic s1, input logic [63:0] exp);
    m = mv; r = rv; sign0 = s0; sign1 = s1; go = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check({tag, " done low"}, 64'(done), 64'd0);
    end
    step();
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " result"}, result, exp);
    go = 1'b0;
    step();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " retained"}, result, exp);
  endtask

  initial begin
    step();
    step();
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    reset_n = 1'b1;
    step();

    run_op("umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("sneg1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    run_op("smin",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'hC000_0000_8000_0000);
    run_op("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001);
    run_op("rsign",  32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);

    // Back-to-back: go held across two operand sets
    m = 32'd3; r = 32'd5; sign0 = 1'b0; sign1 = 1'b0; go = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("b2b first done low", 64'(done), 64'd0);
    end
    step();
    check("b2b first done", 64'(done), 64'd1);
    check("b2b first result", result, 64'd15);
    m = 32'd7; r = 32'd9;
    for (int c = 5; c <= 7; c++) begin
      step();
      check("b2b second done low", 64'(done), 64'd0);
      check("b2b hold 15", result, 64'd15);
    end
    step();
    check("b2b second done", 64'(done), 64'd1);
    check("b2b second result", result, 64'd63);
    go = 1'b0;
    step();
    check("b2b pulse end", 64'(done), 64'd0);

    // Abort: drop go in cycle 2
    m = 32'd100; r = 32'd100; go = 1'b1;
    step();
    step();
    go = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      step();
      check("abort no done", 64'(done), 64'd0);
      check("abort retained", result, 64'd63);
    end
    run_op("after abort", 32'd6, 32'd7, 1'b0, 1'b0, 64'd42);

    // Asynchronous reset in cycle 2
    m = 32'd11; r = 32'd13; go = 1'b1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    go = 1'b0;
    #1;
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset result", result, 64'd0);
    step();
    check("in reset result", result, 64'd0);
    reset_n = 1'b1;
    step();
    check("post reset done", 64'(done), 64'd0);
    run_op("after reset", 32'd11, 32'd13, 1'b0, 1'b0, 64'd143);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
